// File: rtl/bcd_convert_seq.sv
// -----------------------------------------------------------------------------
// bcd_convert_seq
//
// Sequential binary-to-BCD converter. It uses an iterative shift-add-3
// (double-dabble) datapath and converts one operand bit per clock. The
// datapath is sequenced by a three-state FSM (IDLE / SHIFT / DONE) behind a
// start/busy/done handshake.
//
// The output register holds the last completed result. It is updated only when
// the FSM enters DONE, so consumers (for example seven-segment decoders) never
// see partial values while a conversion is running.
//
// Parameters
//   WIDTH   bit width of the binary operand (>= 1)
//   DIGITS  number of decimal digits produced (>= 1)
//
// Ports
//   clk     in   1          system clock, rising edge
//   rst_n   in   1          asynchronous reset, active low
//   start   in   1          conversion request; accepted in IDLE or DONE only
//   number  in   WIDTH      binary operand; sampled only in the accept cycle
//   busy    out  1          conversion in progress (state SHIFT)
//   done    out  1          one-cycle pulse; digits were just updated
//   digits  out  8*DIGITS   lane k = digits[8k+7:8k] = {4'b0000, BCD digit k};
//                           lane 0 holds the units digit
//   ovf     out  1          present only with BCD_OVF_EN; the last result did
//                           not fit in DIGITS digits
//
// Configuration macro
//   BCD_OVF_EN  When this macro is defined, the design adds the ovf port and a
//               sticky overflow flag. The flag is set when a shift pushes a 1
//               out of the top BCD nibble.
//               When it is undefined, results wrap silently modulo 10^DIGITS.
// -----------------------------------------------------------------------------
module bcd_convert_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      number,
   output logic                  busy,
   output logic                  done,
   output logic [8*DIGITS-1:0]   digits
`ifdef BCD_OVF_EN
   ,
   output logic                  ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);   // shift counter width
   localparam int BW = 4 * DIGITS;          // BCD scratch width

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]          state_q,  state_d;
   logic [WIDTH-1:0]    bin_q,    bin_d;
   logic [BW-1:0]       bcd_q,    bcd_d;
   logic [CW-1:0]       cnt_q,    cnt_d;
   logic [8*DIGITS-1:0] digits_q, digits_d;

   logic [BW-1:0]       bcd_adj;       // scratch after the parallel +3 step
   logic [BW-1:0]       bcd_shift;     // scratch after the left shift
   logic [8*DIGITS-1:0] digit_lanes;   // bcd_shift widened to byte lanes
   logic [CW-1:0]       cnt_inc;
   logic                last_shift;
   logic                carry_out;     // bit leaving the top nibble this shift
   logic                accept;
   logic                enter_done;

   // ---------------------------------------------------------------------------
   // Double-dabble step: any nibble >= 5 gets +3 before the shift. All nibbles
   // are adjusted in parallel, so this step forms one stage of combinational
   // logic per clock.
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb gets a default first;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end
      end
   end

   // The operand MSB enters the BCD LSB. The top BCD bit falls off, which gives
   // the modulo-10^DIGITS wrap.
   assign bcd_shift = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
   assign carry_out = bcd_adj[BW-1];

   always_comb begin
      digit_lanes = '0;
      for (int k = 0; k < DIGITS; k++) begin
         digit_lanes[8*k +: 8] = {4'b0000, bcd_shift[4*k +: 4]};
      end
   end

   assign cnt_inc    = cnt_q + 1'b1;
   assign last_shift = (cnt_inc == CW'(WIDTH));

   // ---------------------------------------------------------------------------
   // FSM and datapath next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      digits_d   = digits_q;
      accept     = 1'b0;
      enter_done = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // DONE accepts start as well as IDLE, so back-to-back requests
            // run with no idle cycle between them.
            if (start) begin
               accept  = 1'b1;
               state_d = ST_SHIFT;
               bin_d   = number;
               bcd_d   = '0;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SHIFT: begin
            // start is ignored here: no queueing and no restart.
            bin_d = bin_q << 1;
            bcd_d = bcd_shift;
            cnt_d = cnt_inc;
            if (last_shift) begin
               // The final shift value goes straight into the result register.
               // This makes the result valid in the same cycle as done.
               state_d    = ST_DONE;
               digits_d   = digit_lanes;
               enter_done = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. Every register
   // updates from the values present before the edge, whatever order the
   // statements are written in.
   // NOTE: the datapath registers are reset as well as the FSM. A reset in the
   // middle of a conversion leaves no stale scratch state or result visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         digits_q <= '0;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         digits_q <= digits_d;
      end
   end

`ifdef BCD_OVF_EN
   // ---------------------------------------------------------------------------
   // Overflow tracking. The sticky flag gathers every bit shifted out of the top
   // nibble during one conversion. The output register loads together with
   // digits so that both describe the same result.
   // ---------------------------------------------------------------------------
   logic flag_q, flag_d;
   logic ovf_q,  ovf_d;

   always_comb begin
      flag_d = flag_q;
      ovf_d  = ovf_q;
      if (accept) begin
         flag_d = 1'b0;
      end else if (state_q == ST_SHIFT) begin
         flag_d = flag_q | carry_out;
      end
      if (enter_done) begin
         ovf_d = flag_q | carry_out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         flag_q <= flag_d;
         ovf_q  <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   // Without the overflow option the wrap is silent. These signals stay
   // connected so that the default build has no unused logic.
   logic unused_ovf;
   assign unused_ovf = carry_out & accept;
`endif

   // ---------------------------------------------------------------------------
   // Outputs: decoded straight from the state register, so busy and done are
   // mutually exclusive by construction.
   // ---------------------------------------------------------------------------
   assign busy   = (state_q == ST_SHIFT);
   assign done   = (state_q == ST_DONE);
   assign digits = digits_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bcd_convert_seq
//
// Two converters share clock, reset and stimulus: WIDTH=8 with DIGITS=3, and
// WIDTH=8 with DIGITS=2. The second instance exercises the modulo-100 wrap and,
// when BCD_OVF_EN is defined, the ovf flag.
// Each accepted request pushes its expected result onto a queue. A monitor pops
// and compares an entry on every done pulse.
// -----------------------------------------------------------------------------
module tb_bcd_convert_seq;

   localparam int W = 8;

   logic           clk    = 1'b0;
   logic           rst_n  = 1'b0;
   logic           start  = 1'b0;
   logic [W-1:0]   number = '0;
   logic           busy,  done;
   logic           busy2, done2;
   logic [23:0]    digits;
   logic [15:0]    digits2;
`ifdef BCD_OVF_EN
   logic           ovf, ovf2;
`endif

   typedef struct {
      logic [23:0] d3;
      logic [15:0] d2;
      logic        ovf3;
      logic        ovf2;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_convert_seq #(.WIDTH(W), .DIGITS(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .number (number),
      .busy   (busy),
      .done   (done),
      .digits (digits)
`ifdef BCD_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   bcd_convert_seq #(.WIDTH(W), .DIGITS(2)) dut2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .number (number),
      .busy   (busy2),
      .done   (done2),
      .digits (digits2)
`ifdef BCD_OVF_EN
      ,
      .ovf    (ovf2)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: lane k = (v / 10^k) % 10, computed with plain integer arithmetic.
   function automatic logic [31:0] lanes(input int v, input int nd);
      logic [31:0] r;
      int p;
      r = '0;
      p = 1;
      for (int k = 0; k < nd; k++) begin
         r[8*k +: 8] = 8'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic push_exp(input int v);
      exp_t e;
      e.d3   = 24'(lanes(v, 3));
      e.d2   = 16'(lanes(v, 2));
      e.ovf3 = 1'b0;
      e.ovf2 = (v >= 100);
      sb_q.push_back(e);
   endtask

   // Monitor: sample halfway through the cycle, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done || done2) begin
            check("done_align", done2, done);
         end
         if (done) begin
            check("busy_with_done", busy, 1'b0);
            if (sb_q.size() == 0) begin
               check("unexpected_done", done, 1'b0);
            end else begin
               mon_e = sb_q.pop_front();
               check("digits3", digits,  mon_e.d3);
               check("digits2", digits2, mon_e.d2);
`ifdef BCD_OVF_EN
               check("ovf3", ovf,  mon_e.ovf3);
               check("ovf2", ovf2, mon_e.ovf2);
`endif
            end
         end
      end
   end

   // Drive one start pulse. Edge T0 is the posedge that samples the request.
   task automatic do_start(input int v, input bit expect_result);
      @(negedge clk);
      start  = 1'b1;
      number = W'(v);
      if (expect_result) push_exp(v);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Count negedges until done (bounded); also count the cycles with busy high.
   task automatic wait_done(output int n, output int nb);
      n  = 0;
      nb = 0;
      do begin
         @(negedge clk);
         n++;
         if (busy) nb++;
      end while (!done && n < 40);
      if (!done) check("done_timeout", done, 1'b1);
   endtask

   task automatic run_one(input int v);
      int n, nb;
      do_start(v, 1'b1);
      wait_done(n, nb);
      check("latency", n, 9);
      check("busy_cycles", nb, 8);
   endtask

   initial begin
      int n, nb;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy",    busy,    1'b0);
      check("rst_done",    done,    1'b0);
      check("rst_digits",  digits,  24'h0);
      check("rst_digits2", digits2, 16'h0);
`ifdef BCD_OVF_EN
      check("rst_ovf", ovf2, 1'b0);
`endif
      rst_n = 1'b1;

      // 255 -> 2,5,5 (and 5,5 with overflow on the two-digit instance)
      run_one(255);
      // Operand 0 takes the full latency, then 109 -> 1,0,9
      run_one(0);
      run_one(109);
      // Two-digit instance: 99 fits exactly, ovf clears again
      run_one(99);

      // A start during SHIFT is ignored
      do_start(42, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      start  = 1'b1;
      number = 8'd200;
      @(posedge clk);
      #1 start = 1'b0;
      // 3 negedges are already consumed after T0 (T0+1, T0+2, T0+3 edges).
      wait_done(n, nb);
      check("ignored_latency", n + 3, 9);
      check("ignored_busy", nb, 5);
      repeat (12) @(negedge clk);
      check("ignored_idle", busy, 1'b0);

      // start held high: back-to-back conversions with no idle gap
      @(negedge clk);
      start  = 1'b1;
      number = 8'd128;
      push_exp(128);
      for (int i = 0; i < 3; i++) begin
         wait_done(n, nb);
         check("b2b_latency", n, (i == 0) ? 9 : 8);
         if (i < 2) begin
            push_exp(128);
            @(negedge clk);
            check("b2b_no_gap",  busy,   1'b1);
            check("hold_digits", digits, 24'h010208);
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      check("b2b_idle", busy, 1'b0);

      // Reset in the middle of a conversion
      run_one(99);
      do_start(7, 1'b0);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy",    busy,    1'b0);
      check("abort_done",    done,    1'b0);
      check("abort_digits",  digits,  24'h0);
      check("abort_digits2", digits2, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle", busy, 1'b0);
      check("post_rst_done", done, 1'b0);
      run_one(7);

      // Sweep 1..255 against the integer reference
      for (int v = 1; v < 256; v++) begin
         do_start(v, 1'b1);
         wait_done(n, nb);
         check("sweep_latency", n, 9);
      end

      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
